// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// Package: alu_pkg
// Purpose : Shared constants for the FYsMIPScpu execute-stage ALU.
//           Holds the data/shift-amount widths, the ALUOp encodings and the
//           shifter mode encodings used between alu and alu_shifter.
// Contents:
//   DW, SAW, OPW        data width, shift-amount width, opcode width
//   ALU_ADD..ALU_LUI    ALUOp encodings (1100-1111 are unused)
//   shift_mode_e        barrel-shifter direction/type select
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DW  = 32;
    localparam int SAW = 5;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OPW-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OPW-1:0] ALU_SLL  = 4'b0010;
    localparam logic [OPW-1:0] ALU_OR   = 4'b0011;
    localparam logic [OPW-1:0] ALU_AND  = 4'b0100;
    localparam logic [OPW-1:0] ALU_SLTU = 4'b0101;
    localparam logic [OPW-1:0] ALU_SLT  = 4'b0110;
    localparam logic [OPW-1:0] ALU_XOR  = 4'b0111;
    localparam logic [OPW-1:0] ALU_SRL  = 4'b1000;
    localparam logic [OPW-1:0] ALU_SRA  = 4'b1001;
    localparam logic [OPW-1:0] ALU_NOR  = 4'b1010;
    localparam logic [OPW-1:0] ALU_LUI  = 4'b1011;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// Module : alu_shifter
// Purpose: Combinational 32-bit barrel shifter for SLL, SRL and SRA.
// Ports  :
//   b       in   DW   value to be shifted
//   shamt   in   SAW  shift amount (0 passes b through unchanged)
//   mode    in   2    shift_mode_e: SLL, SRL (logical), SRA (arithmetic)
//   shifted out  DW   shifted value
// ---------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DW-1:0]  b,
    input  logic [SAW-1:0] shamt,
    input  logic [1:0]     mode,
    output logic [DW-1:0]  shifted
);

    always_comb begin
        shifted = b << shamt;
        case (mode)
            SH_SRL:  shifted = b >> shamt;
            SH_SRA:  shifted = $unsigned($signed(b) >>> shamt);
            default: shifted = b << shamt;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// Module : alu
// Purpose: 32-bit MIPS-style integer ALU for the FYsMIPScpu execute stage.
//          Selects operands, applies one of 12 ops chosen by ALUOp and
//          registers the result and zero flag (1-cycle latency).
// Configuration macro: ALU_OVERFLOW_EN
//          When defined, adds a registered 'overflow' output flagging signed
//          overflow of ADD/SUB. When undefined the port and logic are absent.
// Ports  :
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   ALUSrcA    in   1   0: A=ReadData1, 1: A={27'b0,sa}
//   ALUSrcB    in   1   0: B=ReadData2, 1: B=extend
//   ReadData1  in   32  register rs value
//   ReadData2  in   32  register rt value
//   sa         in   5   instruction shift-amount field
//   extend     in   32  extended immediate
//   ALUOp      in   4   operation select
//   zero       out  1   registered (result == 0)
//   result     out  32  registered ALU result
//   overflow   out  1   registered signed ADD/SUB overflow (ALU_OVERFLOW_EN)
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ALUSrcA,
    input  logic            ALUSrcB,
    input  logic [DW-1:0]   ReadData1,
    input  logic [DW-1:0]   ReadData2,
    input  logic [SAW-1:0]  sa,
    input  logic [DW-1:0]   extend,
    input  logic [OPW-1:0]  ALUOp,
`ifdef ALU_OVERFLOW_EN
    output logic            overflow,
`endif
    output logic            zero,
    output logic [DW-1:0]   result
);

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic [DW-1:0] shifted;
    logic [1:0]    shift_mode;
    logic [DW-1:0] next_result;
    logic          next_ovf;

    assign op_a = ALUSrcA ? {{(DW-SAW){1'b0}}, sa} : ReadData1;
    assign op_b = ALUSrcB ? extend : ReadData2;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // Only the low SAW bits of A ever reach the shifter.
    always_comb begin
        shift_mode = SH_SLL;
        case (ALUOp)
            ALU_SRL: shift_mode = SH_SRL;
            ALU_SRA: shift_mode = SH_SRA;
            default: shift_mode = SH_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .b       (op_b),
        .shamt   (op_a[SAW-1:0]),
        .mode    (shift_mode),
        .shifted (shifted)
    );

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
    // wrapped result's sign differs from A.
    always_comb begin
        next_result = '0;
        next_ovf    = 1'b0;
        case (ALUOp)
            ALU_ADD: begin
                next_result = sum;
                next_ovf    = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);
            end
            ALU_SUB: begin
                next_result = diff;
                next_ovf    = (op_a[DW-1] != op_b[DW-1]) && (diff[DW-1] != op_a[DW-1]);
            end
            ALU_SLL:  next_result = shifted;
            ALU_OR:   next_result = op_a | op_b;
            ALU_AND:  next_result = op_a & op_b;
            ALU_SLTU: next_result = {{(DW-1){1'b0}}, (op_a < op_b)};
            ALU_SLT:  next_result = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_XOR:  next_result = op_a ^ op_b;
            ALU_SRL:  next_result = shifted;
            ALU_SRA:  next_result = shifted;
            ALU_NOR:  next_result = ~(op_a | op_b);
            ALU_LUI:  next_result = {op_b[15:0], 16'b0};
            default: begin
                next_result = '0;
                next_ovf    = 1'b0;
            end
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= next_ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = next_ovf;
`endif

    // zero is derived from next_result so it always matches result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= next_result;
            zero   <= (next_result == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// Testbench for alu: directed cases plus a random sweep, with expected values
// pushed to a scoreboard queue when driven and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  sa;
    logic [31:0] extend;
    logic [3:0]  ALUOp;
    logic        zero;
    logic [31:0] result;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    typedef struct {
        logic [31:0] res;
        logic        zro;
        logic        ovf;
    } expect_t;

    expect_t scoreboard[$];
    int testsRun    = 0;
    int testsFailed = 0;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .sa        (sa),
        .extend    (extend),
        .ALUOp     (ALUOp),
`ifdef ALU_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .zero      (zero),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written directly from the opcode table.
    function automatic logic [31:0] modelResult(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = b << a[4:0];
            4'd3:  r = a | b;
            4'd4:  r = a & b;
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  r = a ^ b;
            4'd8:  r = b >> a[4:0];
            4'd9:  r = $unsigned($signed(b) >>> a[4:0]);
            4'd10: r = ~(a | b);
            4'd11: r = {b[15:0], 16'h0000};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Overflow judged by exact wide signed arithmetic rather than sign bits.
    function automatic logic modelOvf(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op);
        longint s;
        if (op == 4'd0)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one op on the falling edge, queues its expectation, then checks
    // the registered outputs just after the next rising edge.
    task automatic applyStimulus(input string tag, input logic srcA, input logic srcB,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [4:0] saIn, input logic [31:0] ext,
                                 input logic [3:0] op);
        expect_t     e;
        expect_t     got;
        logic [31:0] a;
        logic [31:0] b;
        @(negedge clk);
        ALUSrcA   = srcA;
        ALUSrcB   = srcB;
        ReadData1 = rd1;
        ReadData2 = rd2;
        sa        = saIn;
        extend    = ext;
        ALUOp     = op;
        a = srcA ? {27'd0, saIn} : rd1;
        b = srcB ? ext : rd2;
        if (!rst_n) begin
            e.res = 32'd0;
            e.zro = 1'b1;
            e.ovf = 1'b0;
        end else begin
            e.res = modelResult(a, b, op);
            e.zro = (e.res == 32'd0);
            e.ovf = modelOvf(a, b, op);
        end
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        got = scoreboard.pop_front();
        checkOutput({tag, ".result"}, result, got.res);
        checkOutput({tag, ".zero"}, {31'd0, zero}, {31'd0, got.zro});
`ifdef ALU_OVERFLOW_EN
        checkOutput({tag, ".overflow"}, {31'd0, overflow}, {31'd0, got.ovf});
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        ALUSrcA = 1'b0; ALUSrcB = 1'b0; ReadData1 = '0; ReadData2 = '0;
        sa = '0; extend = '0; ALUOp = '0;

        // Reset held for two edges with a live ADD, then released.
        applyStimulus("rst0", 0, 0, 32'd7, 32'd9, 5'd0, 32'd0, 4'd0);
        checkOutput("rst0.const", result, 32'd0);
        applyStimulus("rst1", 0, 0, 32'd7, 32'd9, 5'd0, 32'd0, 4'd0);
        rst_n = 1'b1;
        applyStimulus("addAfterRst", 0, 0, 32'd7, 32'd9, 5'd0, 32'd0, 4'd0);
        checkOutput("addAfterRst.const", result, 32'd16);

        applyStimulus("sub", 0, 0, 32'd8, 32'd2, 5'd0, 32'd0, 4'd1);
        checkOutput("sub.const", result, 32'd6);

        applyStimulus("sllSa", 1, 0, 32'hFFFF_FFE0, 32'h8000_0001, 5'd4, 32'd0, 4'd2);
        checkOutput("sllSa.const", result, 32'h0000_0010);
        applyStimulus("srlSa", 1, 0, 32'hFFFF_FFE0, 32'h8000_0001, 5'd4, 32'd0, 4'd8);
        checkOutput("srlSa.const", result, 32'h0800_0000);
        applyStimulus("sraSa", 1, 0, 32'hFFFF_FFE0, 32'h8000_0001, 5'd4, 32'd0, 4'd9);
        checkOutput("sraSa.const", result, 32'hF800_0000);
        applyStimulus("sraZero", 0, 0, 32'hFFFF_FFE0, 32'h8000_0001, 5'd0, 32'd0, 4'd9);
        checkOutput("sraZero.const", result, 32'h8000_0001);

        applyStimulus("addImm", 0, 1, 32'd1, 32'd5, 5'd0, 32'hFFFF_FFFF, 4'd0);
        checkOutput("addImm.zero", {31'd0, zero}, 32'd1);
        applyStimulus("lui", 0, 1, 32'd1, 32'd5, 5'd0, 32'hFFFF_FFFF, 4'd11);
        checkOutput("lui.const", result, 32'hFFFF_0000);

        applyStimulus("slt", 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 4'd6);
        checkOutput("slt.const", result, 32'd1);
        applyStimulus("sltu", 0, 0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 4'd5);
        checkOutput("sltu.const", result, 32'd0);
        applyStimulus("sltMin", 0, 0, 32'h8000_0000, 32'd1, 5'd0, 32'd0, 4'd6);
        checkOutput("sltMin.const", result, 32'd1);
        applyStimulus("unused", 0, 0, 32'h1234_5678, 32'h0F0F_0F0F, 5'd3, 32'd0, 4'd15);
        checkOutput("unused.zero", {31'd0, zero}, 32'd1);
        applyStimulus("nor", 0, 0, 32'hF0F0_0000, 32'h0000_00FF, 5'd0, 32'd0, 4'd10);
        checkOutput("nor.const", result, 32'h0F0F_FF00);

`ifdef ALU_OVERFLOW_EN
        applyStimulus("ovfAdd", 0, 0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'd0, 4'd0);
        checkOutput("ovfAdd.const", {31'd0, overflow}, 32'd1);
        applyStimulus("ovfSub", 0, 0, 32'h8000_0000, 32'd1, 5'd0, 32'd0, 4'd1);
        checkOutput("ovfSub.const", {31'd0, overflow}, 32'd1);
        applyStimulus("noOvf", 0, 0, 32'd5, 32'd3, 5'd0, 32'd0, 4'd0);
        checkOutput("noOvf.const", {31'd0, overflow}, 32'd0);
`endif

        // Random sweep over every opcode and both operand sources.
        for (int i = 0; i < 60; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
                          4'($urandom_range(0, 15)));
        end

        // Reset asserted mid-stream overrides a live op.
        rst_n = 1'b0;
        applyStimulus("rstMid", 0, 0, 32'd3, 32'd4, 5'd0, 32'd0, 4'd3);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
